// File: rtl/pipeline_sink_buffered.sv
// pipeline_sink_buffered: terminal consumer of the valid/stall/flush chain.
// Words accepted from the last stage are queued in a small first-word-fall-through
// FIFO for a downstream reader. An accepted-word counter and a running checksum
// are kept for bring-up. A flush empties the FIFO and restarts the checksum.
module pipeline_sink_buffered #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       in_flush,
    input  logic                       force_stall,
    output logic                       out_stall,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                accepted_count,
    output logic [31:0]                checksum
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage has no reset; emptiness is tracked by count_reg, and rd_data is
    // masked while empty, so stale contents are never visible.
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      accepted_count_reg;
    logic [31:0]      checksum_reg;

    logic             accept;
    logic             pop;
    logic [31:0]      in_data_32;

    // Checksum always operates on 32 bits: narrow words are zero-extended,
    // wide words are truncated.
    generate
        if (WIDTH >= 32) begin : g_trunc
            assign in_data_32 = in_data[31:0];
        end else begin : g_ext
            assign in_data_32 = {{(32 - WIDTH){1'b0}}, in_data};
        end
    endgenerate

    // Backpressure is driven only from registered occupancy and the debug
    // input, so there is no combinational path from in_valid to out_stall.
    assign out_stall = force_stall | (count_reg >= CNT_W'(STALL_THRESH));

    // A flush cycle swallows both the incoming word and any read request.
    assign accept = in_valid & ~out_stall & ~in_flush;
    assign pop    = rd_en & rd_valid & ~in_flush;

    // Fall-through head read; zero whenever the FIFO is empty.
    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? mem_reg[rd_ptr_reg] : '0;

    assign count          = count_reg;
    assign accepted_count = accepted_count_reg;
    assign checksum       = checksum_reg;

    // Write the accepted word at the tail.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

    // Pointers and occupancy: flush empties the queue; otherwise accept and
    // pop move their own pointer, and cancel out in count when both happen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (in_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (accept && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !accept) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Accepted-word counter survives flushes; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accepted_count_reg <= '0;
        end else if (accept) begin
            accepted_count_reg <= accepted_count_reg + 32'd1;
        end
    end

    // Running checksum of words accepted since the last flush or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_reg <= '0;
        end else if (in_flush) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + in_data_32;
        end
    end

endmodule

// File: tb/tb_pipeline_sink_buffered.sv
// Bench for pipeline_sink_buffered. A queue-based model tracks what the sink
// should hold; directed scenarios follow the test plan, then a randomized run
// compares every output each cycle. A second instance covers STALL_THRESH=2.
module tb_pipeline_sink_buffered;

    logic        clk;
    logic        reset;

    // Main instance: DEPTH=4, STALL_THRESH=4
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_flush;
    logic        force_stall;
    logic        out_stall;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  count;
    logic [31:0] accepted_count;
    logic [31:0] checksum;

    // Second instance: DEPTH=4, STALL_THRESH=2
    logic [31:0] in_data2;
    logic        in_valid2;
    logic        in_flush2;
    logic        force_stall2;
    logic        out_stall2;
    logic        rd_en2;
    logic [31:0] rd_data2;
    logic        rd_valid2;
    logic [2:0]  count2;
    logic [31:0] accepted_count2;
    logic [31:0] checksum2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_acc;
    logic [31:0] m_sum;

    pipeline_sink_buffered #(.WIDTH(32), .DEPTH(4), .STALL_THRESH(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_flush(in_flush),
        .force_stall(force_stall), .out_stall(out_stall),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .accepted_count(accepted_count), .checksum(checksum)
    );

    pipeline_sink_buffered #(.WIDTH(32), .DEPTH(4), .STALL_THRESH(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_flush(in_flush2),
        .force_stall(force_stall2), .out_stall(out_stall2),
        .rd_en(rd_en2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .count(count2), .accepted_count(accepted_count2), .checksum(checksum2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_head();
        return (mq.size() > 0) ? mq[0] : 32'd0;
    endfunction

    // Drive one cycle on the main instance from a negedge, update the model
    // at the posedge from the rules, and return at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic f,
                        input logic r, input logic fs);
        logic stall, acc, pop;
        in_valid = v; in_data = d; in_flush = f; rd_en = r; force_stall = fs;
        stall = fs || (mq.size() >= 4);
        acc   = v && !stall && !f;
        pop   = r && (mq.size() > 0) && !f;
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_sum = 32'd0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                m_acc = m_acc + 32'd1;
                m_sum = m_sum + d;
            end
        end
        @(negedge clk);
    endtask

    // One edge on the second instance.
    task automatic step2(input logic v, input logic [31:0] d, input logic f,
                         input logic r, input logic fs);
        in_valid2 = v; in_data2 = d; in_flush2 = f; rd_en2 = r; force_stall2 = fs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_flush = 0; rd_en = 0; force_stall = 0;
        in_valid2 = 0; in_data2 = 0; in_flush2 = 0; rd_en2 = 0; force_stall2 = 0;
        mq.delete(); m_acc = 0; m_sum = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({count, rd_valid, rd_data, accepted_count, checksum, out_stall} !== '0) begin
            errors++;
            $display("FAIL reset_state: count=%0d rd_valid=%b rd_data=%h acc=%0d sum=%h stall=%b required all 0",
                     count, rd_valid, rd_data, accepted_count, checksum, out_stall);
        end
        force_stall = 1'b1;
        #1;
        checks++;
        if (out_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_force_stall: out_stall=%b required 1", out_stall);
        end
        force_stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        step(1, 32'h11, 0, 0, 0);
        step(1, 32'h22, 0, 0, 0);
        step(1, 32'h33, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        checks++;
        if (count !== 3'd3 || out_stall !== 1'b0 || rd_data !== 32'h11) begin
            errors++;
            $display("FAIL fill3: count=%0d stall=%b rd_data=%h required 3 0 11", count, out_stall, rd_data);
        end
        checks++;
        if (checksum !== 32'h66 || accepted_count !== 32'd3) begin
            errors++;
            $display("FAIL fill3_sum: sum=%h acc=%0d required 66 3", checksum, accepted_count);
        end
    endtask

    task automatic test_full_stall();
        step(1, 32'h44, 0, 0, 0);
        checks++;
        if (count !== 3'd4 || out_stall !== 1'b1) begin
            errors++;
            $display("FAIL full: count=%0d stall=%b required 4 1", count, out_stall);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h55, 0, 0, 0);
            checks++;
            if (accepted_count !== 32'd4 || count !== 3'd4) begin
                errors++;
                $display("FAIL full_hold%0d: acc=%0d count=%0d required 4 4", i, accepted_count, count);
            end
        end
        step(1, 32'h55, 0, 1, 0);
        checks++;
        if (count !== 3'd3 || out_stall !== 1'b0 || rd_data !== 32'h22) begin
            errors++;
            $display("FAIL full_pop: count=%0d stall=%b rd_data=%h required 3 0 22", count, out_stall, rd_data);
        end
        step(1, 32'h55, 0, 0, 0);
        checks++;
        if (count !== 3'd4 || accepted_count !== 32'd5 || checksum !== m_sum) begin
            errors++;
            $display("FAIL full_refill: count=%0d acc=%0d sum=%h required 4 5 %h",
                     count, accepted_count, checksum, m_sum);
        end
        step(0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] sum_before;
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        checks++;
        if (count !== 3'd2 || rd_data !== 32'h44) begin
            errors++;
            $display("FAIL pre_simul: count=%0d rd_data=%h required 2 44", count, rd_data);
        end
        sum_before = checksum;
        step(1, 32'hA0, 0, 1, 0);
        checks++;
        if (count !== 3'd2 || rd_data !== 32'h55 || checksum !== sum_before + 32'hA0) begin
            errors++;
            $display("FAIL simul: count=%0d rd_data=%h sum=%h required 2 55 %h",
                     count, rd_data, checksum, sum_before + 32'hA0);
        end
        step(0, 32'h0, 0, 1, 0);
        checks++;
        if (count !== 3'd1 || rd_data !== 32'hA0) begin
            errors++;
            $display("FAIL simul_tail: count=%0d rd_data=%h required 1 a0", count, rd_data);
        end
    endtask

    task automatic test_flush();
        logic [31:0] acc_before;
        step(1, 32'hB1, 0, 0, 0);
        step(1, 32'hB2, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL pre_flush: count=%0d required 3", count);
        end
        acc_before = accepted_count;
        step(1, 32'hFF, 1, 1, 0);
        checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL flush: count=%0d rd_valid=%b rd_data=%h sum=%h required 0 0 0 0",
                     count, rd_valid, rd_data, checksum);
        end
        checks++;
        if (accepted_count !== acc_before) begin
            errors++;
            $display("FAIL flush_acc: acc=%0d required %0d", accepted_count, acc_before);
        end
        step(0, 32'h0, 0, 1, 0);
        checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_rd: count=%0d rd_valid=%b required 0 0", count, rd_valid);
        end
    endtask

    task automatic test_thresh2();
        step2(1, 32'h11, 0, 0, 0);
        checks++;
        if (count2 !== 3'd1 || out_stall2 !== 1'b0) begin
            errors++;
            $display("FAIL th2_one: count=%0d stall=%b required 1 0", count2, out_stall2);
        end
        step2(1, 32'h22, 0, 0, 0);
        checks++;
        if (count2 !== 3'd2 || out_stall2 !== 1'b1) begin
            errors++;
            $display("FAIL th2_two: count=%0d stall=%b required 2 1", count2, out_stall2);
        end
        step2(1, 32'h33, 0, 0, 0);
        checks++;
        if (count2 !== 3'd2 || accepted_count2 !== 32'd2) begin
            errors++;
            $display("FAIL th2_hold: count=%0d acc=%0d required 2 2", count2, accepted_count2);
        end
        step2(0, 32'h0, 1, 0, 0);
        step2(1, 32'h77, 0, 0, 1);
        step2(1, 32'h77, 0, 0, 1);
        checks++;
        if (out_stall2 !== 1'b1 || count2 !== 3'd0 || accepted_count2 !== 32'd2) begin
            errors++;
            $display("FAIL th2_force: stall=%b count=%0d acc=%0d required 1 0 2",
                     out_stall2, count2, accepted_count2);
        end
        step2(1, 32'h77, 0, 0, 0);
        checks++;
        if (count2 !== 3'd1 || checksum2 !== 32'h77 || rd_data2 !== 32'h77) begin
            errors++;
            $display("FAIL th2_release: count=%0d sum=%h rd_data=%h required 1 77 77",
                     count2, checksum2, rd_data2);
        end
        step2(0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic        v, f, r, fs;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 29) == 0);
            fs = ($urandom_range(0, 9) == 0);
            d  = $urandom;
            step(v, d, f, r, fs);
            checks++;
            if (count !== 3'(mq.size()) || rd_valid !== (mq.size() > 0) || rd_data !== m_head()) begin
                errors++;
                $display("FAIL rand_fifo[%0d]: count=%0d valid=%b data=%h required %0d %b %h",
                         i, count, rd_valid, rd_data, mq.size(), (mq.size() > 0), m_head());
            end
            checks++;
            if (accepted_count !== m_acc || checksum !== m_sum) begin
                errors++;
                $display("FAIL rand_stats[%0d]: acc=%0d sum=%h required %0d %h",
                         i, accepted_count, checksum, m_acc, m_sum);
            end
            checks++;
            if (out_stall !== (fs || mq.size() >= 4)) begin
                errors++;
                $display("FAIL rand_stall[%0d]: stall=%b required %b", i, out_stall, (fs || mq.size() >= 4));
            end
        end
        step(0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'hC1, 0, 0, 0);
        step(1, 32'hC2, 0, 0, 0);
        step(1, 32'hC3, 0, 0, 0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL pre_areset: count=%0d required 3", count);
        end
        // Keep the burst going and hit reset between edges.
        in_valid = 1; in_data = 32'hC4;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({count, rd_valid, rd_data, accepted_count, checksum, out_stall} !== '0) begin
            errors++;
            $display("FAIL areset: count=%0d rd_valid=%b rd_data=%h acc=%0d sum=%h stall=%b required all 0",
                     count, rd_valid, rd_data, accepted_count, checksum, out_stall);
        end
        in_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        mq.delete(); m_acc = 0; m_sum = 0;
        step(1, 32'h01, 0, 0, 0);
        checks++;
        if (checksum !== 32'h01 || accepted_count !== 32'd1 || count !== 3'd1) begin
            errors++;
            $display("FAIL post_areset: sum=%h acc=%0d count=%0d required 1 1 1",
                     checksum, accepted_count, count);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic_fill();
        test_full_stall();
        test_simul_push_pop();
        test_flush();
        test_thresh2();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

endmodule
